// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer: one holding register feeds a shift register so back-to-back words
// stream without bubbles. Define PARALLEL_TO_SERIAL_MSB_FIRST_EN to send bit width-1 first.
module parallel_to_serial #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    input  logic             serial_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last
);

    localparam int unsigned CntW = (width > 2) ? $clog2(width) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(width - 1);

    logic [width-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [width-1:0] shreg_q, shreg_d;
    logic             busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic xfer, last_xfer, load, accept;
    logic [width-1:0] shreg_shifted;
    logic             cur_bit;

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    assign shreg_shifted = {shreg_q[width-2:0], 1'b0};
    assign cur_bit       = shreg_q[width-1];
`else
    assign shreg_shifted = {1'b0, shreg_q[width-1:1]};
    assign cur_bit       = shreg_q[0];
`endif

    assign xfer      = busy_q & serial_ready;
    assign last_xfer = xfer & (cnt_q == CntLast);
    // Shifter is free when idle or when its final bit leaves at this edge.
    assign load      = hold_valid_q & (~busy_q | last_xfer);
    assign accept    = parallel_valid & ~hold_valid_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shreg_d      = shreg_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;

        if (accept) begin
            hold_d       = parallel_data;
            hold_valid_d = 1'b1;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end

        if (load) begin
            shreg_d = hold_q;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end else if (last_xfer) begin
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (xfer) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        parallel_ready = ~hold_valid_q;
        serial_valid   = busy_q;
        serial_data    = busy_q & cur_bit;
        serial_last    = busy_q & (cnt_q == CntLast);
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial (width 8): accepted words are expanded into expected
// bits by a reference model; a negedge monitor pops and compares every transferred bit.
module tb_parallel_to_serial;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         parallel_valid = 1'b0;
    logic [W-1:0] parallel_data = '0;
    logic         parallel_ready;
    logic         serial_ready = 1'b1;
    logic         serial_valid;
    logic         serial_data;
    logic         serial_last;

    parallel_to_serial #(.width(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready),
        .serial_ready   (serial_ready),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_last    (serial_last)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int run     = 0;
    int last_run = 0;
    int bits_done = 0;
    logic [1:0] exp_q[$];  // {last, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes width bits in transmission order; only the final one is last.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < int'(W); i++) begin
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
            exp_q.push_back({i == int'(W) - 1, w[W-1-i]});
`else
            exp_q.push_back({i == int'(W) - 1, w[i]});
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: accept detection, bit scoreboard, stall stability, contiguous-valid run length.
    initial begin
        logic       prev_stall;
        logic       prev_data;
        logic       prev_last;
        logic [1:0] e;
        prev_stall = 1'b0;
        prev_data  = 1'b0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
                prev_stall = 1'b0;
            end else begin
                if (parallel_valid && parallel_ready) push_word(parallel_data);
                if (serial_valid) begin
                    run++;
                    if (prev_stall) begin
                        check("stall_data", serial_data, prev_data);
                        check("stall_last", serial_last, prev_last);
                    end
                    if (serial_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_bit", serial_valid, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("bit_data", serial_data, e[0]);
                            check("bit_last", serial_last, e[1]);
                        end
                        bits_done++;
                        prev_stall = 1'b0;
                    end else begin
                        prev_stall = 1'b1;
                        prev_data  = serial_data;
                        prev_last  = serial_last;
                    end
                end else begin
                    check("idle_data", serial_data, 0);
                    check("idle_last", serial_last, 0);
                    if (run != 0) last_run = run;
                    run = 0;
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic send_word(input logic [W-1:0] w);
        int k;
        parallel_valid = 1'b1;
        parallel_data  = w;
        k = 0;
        @(negedge clk);
        while (!parallel_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_timeout", parallel_ready, 1);
        @(posedge clk);
        #1 parallel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((serial_valid || !parallel_ready || exp_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", serial_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while (bits_done < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("bits_timeout", 32'(bits_done >= n), 1);
    endtask

    initial begin
        int t1, t2, t3, seen, base;
        logic took;

        // Reset: outputs idle, ready high while reset is asserted
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", parallel_ready, 1);
        check("rst_valid", serial_valid, 0);
        check("rst_data", serial_data, 0);
        check("rst_last", serial_last, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        check("post_rst_ready", parallel_ready, 1);

        // Single word: one cycle in hold, then 8 valid bits
        send_word(8'hB4);
        check("hold_cycle_valid", serial_valid, 0);
        check("hold_cycle_ready", parallel_ready, 0);
        @(posedge clk);
        #1;
        check("first_bit_valid", serial_valid, 1);
        check("ready_recovery", parallel_ready, 1);
        wait_idle();
        check("single_run", last_run, 8);

        // Back-to-back: 16 contiguous valid cycles
        send_word(8'h3C);
        send_word(8'hC3);
        wait_idle();
        check("b2b_run", last_run, 16);

        // Backpressure after bit 3 with a second word waiting in hold
        base = bits_done;
        send_word(8'hB4);
        send_word(8'h5A);
        wait_bits(base + 3);
        serial_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_hold_full", parallel_ready, 0);
        end
        serial_ready = 1'b1;
        wait_idle();
        check("bp_run", last_run, 8 + 3 + 8);

        // Holding full: third word accepted only after the second loads
        parallel_valid = 1'b1;
        send_word(8'h11);
        t1 = cyc;
        send_word(8'h22);
        t2 = cyc;
        send_word(8'h33);
        t3 = cyc;
        check("accept2_gap", t2 - t1, 2);
        check("accept3_gap", t3 - t2, 8);
        wait_idle();
        check("full_run", last_run, 24);

        // Reset during the 5th bit
        base = bits_done;
        send_word(8'hE7);
        wait_bits(base + 4);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", serial_valid, 0);
        check("midrst_data", serial_data, 0);
        check("midrst_last", serial_last, 0);
        check("midrst_ready", parallel_ready, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (serial_valid) seen++;
        end
        check("no_residual", seen, 0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            took = parallel_valid && parallel_ready;
            @(posedge clk);
            #1;
            if (took || !parallel_valid) begin
                parallel_valid = 1'($urandom_range(0, 1));
                parallel_data  = W'($urandom);
            end
            serial_ready = ($urandom_range(0, 3) != 0);
        end
        parallel_valid = 1'b0;
        serial_ready   = 1'b1;
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
